// File: rtl/gen_ctrl_pkg.sv
// Shared types and constants for the generation step controller.
package gen_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      ISSUE = 2'd2,
      ACK   = 2'd3
   } state_t;

   localparam int unsigned MIN_PERIOD = 1;

endpackage

// File: rtl/gen_step_ctrl_period_timer.sv
// Inter-generation down-counter; a zero period is clamped to MIN_PERIOD on load.
module period_timer
   import gen_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD_W = 24
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                load,
   input  logic [PERIOD_W-1:0] value,
   input  logic                dec,
   output logic                zero
);

   localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);
   localparam logic [PERIOD_W-1:0] MIN_VAL = PERIOD_W'(MIN_PERIOD);

   logic [PERIOD_W-1:0] count;

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= ((value == '0) ? MIN_VAL : value) - ONE;
      end else if (dec && (count != '0)) begin
         count <= count - ONE;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/gen_step_ctrl.sv
// Paces Game-of-Life generations: issues gen_en pulses, waits for gen_done, counts generations.
// Optional generation limit (max_gen / limit_hit) is built when GEN_LIMIT_EN is defined.
module gen_step_ctrl
   import gen_ctrl_pkg::*;
#(
   parameter int unsigned PERIOD_W = 24,
   parameter int unsigned GEN_W    = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                run,
   input  logic                step,
   input  logic                clear,
   input  logic [PERIOD_W-1:0] period,
   input  logic                gen_done,
`ifdef GEN_LIMIT_EN
   input  logic [GEN_W-1:0]    max_gen,
   output logic                limit_hit,
`endif
   output logic                start,
   output logic                gen_en,
   output logic                busy,
   output logic [GEN_W-1:0]    gen_count
);

   state_t state, state_nxt;
   logic   clr_pend, clr_now, clr_apply;
   logic   t_load, t_dec, t_zero;
   logic   at_limit;

   period_timer #(.PERIOD_W(PERIOD_W)) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (t_load),
      .value (period),
      .dec   (t_dec),
      .zero  (t_zero)
   );

`ifdef GEN_LIMIT_EN
   assign at_limit = (max_gen != '0) && (gen_count == max_gen);
`else
   assign at_limit = 1'b0;
`endif

   assign clr_now   = clear | clr_pend;
   assign clr_apply = (state == ACK) && gen_done && clr_now;

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      t_load    = 1'b0;
      case (state)
         IDLE: begin
            if (clear || at_limit) begin
               state_nxt = IDLE;
            end else if (run) begin
               state_nxt = WAIT;
               t_load    = 1'b1;
            end else if (step) begin
               state_nxt = ISSUE;
            end
         end
         WAIT: begin
            if (clear || !run || at_limit) state_nxt = IDLE;
            else if (t_zero)               state_nxt = ISSUE;
         end
         ISSUE: state_nxt = ACK;
         ACK: begin
            if (gen_done) begin
               if (clr_now || !run) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt = WAIT;
                  t_load    = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      gen_en = (state == ISSUE);
      busy   = (state != IDLE);
      t_dec  = (state == WAIT);
   end

   // clear arriving in ISSUE/ACK is parked in clr_pend and applied as ACK exits
   always_ff @(posedge clk) begin
      if (!reset) begin
         start     <= 1'b0;
         gen_count <= '0;
         clr_pend  <= 1'b0;
      end else if (clr_apply) begin
         start     <= 1'b0;
         gen_count <= '0;
         clr_pend  <= 1'b0;
      end else if ((state == ISSUE) || (state == ACK)) begin
         if (clear) clr_pend <= 1'b1;
         if (state == ISSUE) begin
            start     <= 1'b1;
            gen_count <= gen_count + GEN_W'(1);
         end
      end else if (clear) begin
         start     <= 1'b0;
         gen_count <= '0;
      end
   end

`ifdef GEN_LIMIT_EN
   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         limit_hit <= 1'b0;
      end else if (((state == IDLE) || (state == WAIT)) && at_limit) begin
         limit_hit <= 1'b1;
      end
   end
`endif

endmodule
